// File: rtl/stream_mux_pkg.sv
// Shared constants, lock-FSM state type and selector-width helper for stream_mux_n_to_1.
package stream_mux_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_e;

  // Selector width: $clog2(n), but never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// Request arbiter: fixed priority (lowest index) or round-robin from an internal pointer.
// hold freezes the grant on the index granted in the last un-held cycle.
module stream_rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned ARB_MODE = ARB_FIXED,
  localparam int unsigned SW      = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic          hold,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] held_q;
  logic [SW-1:0] start_c;
  logic [SW-1:0] search_c;
  logic [SW-1:0] ptr_next_c;
  logic          found_c;

  assign start_c = (ARB_MODE == ARB_RR) ? ptr_q : '0;

  // First requester scanning start_c, start_c+1, ... modulo N.
  always_comb begin
    int unsigned idx;
    search_c = '0;
    found_c  = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(start_c) + k;
      if (idx >= N) idx = idx - N;
      if (!found_c && req[idx]) begin
        found_c  = 1'b1;
        search_c = SW'(idx);
      end
    end
  end

  assign grant       = hold ? held_q : search_c;
  assign grant_valid = req[grant];
  assign ptr_next_c  = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      held_q <= '0;
    end else begin
      if (!hold) held_q <= search_c;
      if (advance && (ARB_MODE == ARB_RR)) ptr_q <= ptr_next_c;
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 valid/ready stream multiplexer with a one-entry registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux_n_to_1
  import stream_mux_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned ARB_MODE = ARB_FIXED,
  localparam int unsigned SW      = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] grant_c;
  logic          grant_valid_c;
  logic          load_ok_c;
  logic          xfer_c;
  logic          advance_c;
  logic          hold_c;
  logic [W-1:0]  data_c;

  stream_rr_arbiter #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (advance_c),
    .hold        (hold_c),
    .grant       (grant_c),
    .grant_valid (grant_valid_c)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign load_ok_c = !out_valid || out_ready;
  assign xfer_c    = rst_n && grant_valid_c && load_ok_c;

  always_comb begin
    in_ready = '0;
    data_c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c == SW'(i)) begin
        in_ready[i] = xfer_c;
        data_c      = in_data[i*W +: W];
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e state_q;
  lock_state_e state_d;
  logic        last_c;

  assign last_c    = in_last[grant_c];
  assign hold_c    = (state_q == ST_LOCKED);
  assign advance_c = xfer_c && last_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer_c && !last_c) state_d = ST_LOCKED;
      ST_LOCKED: if (xfer_c && last_c)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      out_last <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer_c) out_last <= last_c;
    end
  end
`else
  assign hold_c    = 1'b0;
  assign advance_c = xfer_c;
`endif

  // Output register: data/sel hold while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= data_c;
      out_sel   <= grant_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Directed bench: a fixed-priority and a round-robin mux share one stimulus stream.
module tb_stream_mux_n_to_1;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0] f_in_ready, r_in_ready;
  logic         f_valid, r_valid;
  logic [W-1:0] f_data, r_data;
  logic [1:0]   f_sel, r_sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0] in_last;
  logic         f_last, r_last;
`endif

  int vectors = 0;
  int miscompares = 0;
  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  always #5 clk = ~clk;

  stream_mux_n_to_1 #(.N(N), .W(W), .ARB_MODE(0)) u_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (f_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (f_last),
`endif
    .out_valid (f_valid),
    .out_data  (f_data),
    .out_sel   (f_sel),
    .out_ready (out_ready)
  );

  stream_mux_n_to_1 #(.N(N), .W(W), .ARB_MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (r_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (r_last),
`endif
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_sel   (r_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h3322_1100;
    out_ready = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last   = 4'b1111;
`endif
    #2;
    chk("rst_f_in_ready", 32'(f_in_ready), 32'h0);
    chk("rst_r_in_ready", 32'(r_in_ready), 32'h0);
    chk("rst_f_valid", 32'(f_valid), 32'h0);
    chk("rst_r_data", 32'(r_data), 32'h0);
    chk("rst_r_sel", 32'(r_sel), 32'h0);

    // Fixed priority starves ch1..3; round-robin rotates through all four.
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("first_f_in_ready", 32'(f_in_ready), 32'h1);
    chk("first_r_in_ready", 32'(r_in_ready), 32'h1);
    tick();
    chk("fix_valid0", 32'(f_valid), 32'h1);
    chk("fix_sel0", 32'(f_sel), 32'h0);
    chk("rr_sel0", 32'(r_sel), 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("fix_sel_starve", 32'(f_sel), 32'h0);
      chk("fix_in_ready_starve", 32'(f_in_ready), 32'h1);
      chk("rr_sel_all", 32'(r_sel), 32'(k));
      chk("rr_data_all", 32'(r_data), 32'(k * 8'h11));
    end

    // Reset mid-traffic takes effect immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_f_valid", 32'(f_valid), 32'h0);
    chk("midrst_r_valid", 32'(r_valid), 32'h0);
    chk("midrst_f_in_ready", 32'(f_in_ready), 32'h0);
    chk("midrst_r_in_ready", 32'(r_in_ready), 32'h0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1011;
    #1;
    chk("post_rst_r_in_ready", 32'(r_in_ready), 32'h1);

    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_sel_1011", 32'(r_sel), 32'(rr_exp[i]));
      chk("rr_valid_1011", 32'(r_valid), 32'h1);
      chk("rr_data_1011", 32'(r_data), 32'(rr_exp[i] * 8'h11));
      chk("fix_sel_1011", 32'(f_sel), 32'h0);
    end

    // Backpressure: output held, no input accepted.
    out_ready = 1'b0;
    #1;
    chk("bp_r_in_ready", 32'(r_in_ready), 32'h0);
    chk("bp_f_in_ready", 32'(f_in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_r_sel", 32'(r_sel), 32'h3);
      chk("bp_r_data", 32'(r_data), 32'h33);
      chk("bp_r_valid", 32'(r_valid), 32'h1);
      chk("bp_r_in_ready_hold", 32'(r_in_ready), 32'h0);
      chk("bp_f_data", 32'(f_data), 32'h00);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_r_in_ready", 32'(r_in_ready), 32'h1);
    tick();
    chk("rel_r_sel", 32'(r_sel), 32'h0);
    chk("rel_r_valid", 32'(r_valid), 32'h1);
    tick();
    chk("rel_r_sel2", 32'(r_sel), 32'h1);
    chk("rel_r_data2", 32'(r_data), 32'h11);

    // Idle: valid drops, data holds, RR pointer stays after ch1.
    in_valid = 4'b0000;
    tick();
    chk("idle_r_valid", 32'(r_valid), 32'h0);
    chk("idle_r_data", 32'(r_data), 32'h11);
    chk("idle_f_valid", 32'(f_valid), 32'h0);
    tick();
    tick();
    in_valid = 4'b1011;
    #1;
    chk("idle_ptr_r_in_ready", 32'(r_in_ready), 32'h8);
    chk("idle_f_in_ready", 32'(f_in_ready), 32'h1);
    tick();
    chk("idle_r_sel", 32'(r_sel), 32'h3);
    chk("idle_r_data_new", 32'(r_data), 32'h33);
    in_valid = 4'b1010;
    #1;
    chk("fix_lowest_1010", 32'(f_in_ready), 32'h2);
    chk("rr_next_1010", 32'(r_in_ready), 32'h2);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: ch2 holds the grant for three beats while ch0 waits.
    rst_n = 1'b0;
    #1;
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    #1;
    chk("pkt_b1_in_ready", 32'(f_in_ready), 32'h4);
    tick();
    chk("pkt_b1_f_sel", 32'(f_sel), 32'h2);
    chk("pkt_b1_r_sel", 32'(r_sel), 32'h2);
    chk("pkt_b1_last", 32'(f_last), 32'h0);
    in_valid = 4'b0101;
    #1;
    chk("pkt_lock_f_in_ready", 32'(f_in_ready), 32'h4);
    chk("pkt_lock_r_in_ready", 32'(r_in_ready), 32'h4);
    tick();
    chk("pkt_b2_f_sel", 32'(f_sel), 32'h2);
    chk("pkt_b2_r_sel", 32'(r_sel), 32'h2);
    in_valid = 4'b0001;
    #1;
    chk("pkt_gap_f_in_ready", 32'(f_in_ready), 32'h0);
    chk("pkt_gap_r_in_ready", 32'(r_in_ready), 32'h0);
    tick();
    in_valid = 4'b0101;
    in_last  = 4'b0101;
    #1;
    chk("pkt_b3_in_ready", 32'(f_in_ready), 32'h4);
    tick();
    chk("pkt_b3_f_sel", 32'(f_sel), 32'h2);
    chk("pkt_b3_f_last", 32'(f_last), 32'h1);
    chk("pkt_b3_r_last", 32'(r_last), 32'h1);
    #1;
    chk("pkt_unlock_f_in_ready", 32'(f_in_ready), 32'h1);
    chk("pkt_unlock_r_in_ready", 32'(r_in_ready), 32'h1);
    tick();
    chk("pkt_after_f_sel", 32'(f_sel), 32'h0);
    chk("pkt_after_r_sel", 32'(r_sel), 32'h0);

    // Reset while locked clears the lock and the RR pointer.
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    #1;
    chk("pkt2_r_in_ready", 32'(r_in_ready), 32'h4);
    tick();
    chk("pkt2_b1_r_sel", 32'(r_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("pkt2_rst_valid", 32'(f_valid), 32'h0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b0101;
    #1;
    chk("pkt2_unlock_f_in_ready", 32'(f_in_ready), 32'h1);
    chk("pkt2_unlock_r_in_ready", 32'(r_in_ready), 32'h1);
    in_last = 4'b1111;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
